// File: rtl/lotr_pkg.sv
// Ring-wide fabric message opcodes shared by every agent on the ring.
package lotr_pkg;
    typedef enum logic [1:0] {
        RD     = 2'd0,
        RD_RSP = 2'd1,
        WR     = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;
endpackage

// File: rtl/uart_io_pkg.sv
// Shared types for the UART-to-fabric bridge: command bytes, FSM states, request/response records.
package uart_io_pkg;
    import lotr_pkg::*;

    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_ISSUE_WR, S_ISSUE_RD, S_WAIT_RSP, S_SEND
    } t_cmd_state;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} t_rx_state;

    typedef struct packed {
        logic        valid;
        t_opcode     opcode;
        logic [1:0]  tid;
        logic [31:0] addr;
        logic [31:0] data;
    } t_c2f_req;

    typedef struct packed {
        logic        valid;
        t_opcode     opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } t_f2c_rsp;
endpackage

// File: rtl/uart_io_phy.sv
// UART character engine: synchronised RX deserializer and TX serializer, one stop bit, no parity.
module uart_io_phy
    import uart_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2083,
    parameter int N_DATA_BITS  = 8,
    parameter int LSB_FIRST    = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   rx_line,
    output logic [N_DATA_BITS-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_frame_err,
    input  logic                   tx_valid,
    input  logic [N_DATA_BITS-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   tx_line
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(N_DATA_BITS + 2);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [2:0]             rx_sync;
    t_rx_state              rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_idx;
    logic                   rx_bit;
    logic                   rx_fall;
    logic [N_DATA_BITS-1:0] rx_next;

    // rx_sync[2] is the previous synchronised sample, used only for edge detection
    assign rx_bit  = rx_sync[1];
    assign rx_fall = rx_sync[2] & ~rx_sync[1];
    assign rx_next = (LSB_FIRST != 0) ? {rx_bit, rx_data[N_DATA_BITS-1:1]}
                                      : {rx_data[N_DATA_BITS-2:0], rx_bit};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_sync      <= 3'b111;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[1:0], rx_line};
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            unique case (rx_state)
                RX_IDLE: if (rx_fall) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_bit ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_DATA: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_cnt  <= '0;
                    rx_data <= rx_next;
                    rx_idx  <= rx_idx + 1'b1;
                    if (rx_idx == BW'(N_DATA_BITS - 1)) rx_state <= RX_STOP;
                end else rx_cnt <= rx_cnt + 1'b1;
                RX_STOP: if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    rx_state     <= RX_IDLE;
                    rx_valid     <= rx_bit;
                    rx_frame_err <= ~rx_bit;
                end else rx_cnt <= rx_cnt + 1'b1;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic                   tx_busy;
    logic [N_DATA_BITS:0]   tx_sh;
    logic [BW-1:0]          tx_left;
    logic [CW-1:0]          tx_cnt;
    logic [N_DATA_BITS-1:0] tx_ord;

    // The shifter always emits bit 0 first, so MSB-first data is bit-reversed on load
    always_comb begin
        tx_ord = tx_data;
        if (LSB_FIRST == 0)
            for (int i = 0; i < N_DATA_BITS; i++) tx_ord[i] = tx_data[N_DATA_BITS-1-i];
    end

    assign tx_ready = ~tx_busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tx_sh   <= '0;
            tx_left <= '0;
            tx_cnt  <= '0;
        end else if (!tx_busy) begin
            if (tx_valid) begin
                tx_busy <= 1'b1;
                tx_line <= 1'b0;
                tx_sh   <= {1'b1, tx_ord};
                tx_left <= BW'(N_DATA_BITS + 1);
                tx_cnt  <= '0;
            end
        end else if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_left == '0) tx_busy <= 1'b0;
            else begin
                tx_line <= tx_sh[0];
                tx_sh   <= {1'b0, tx_sh[N_DATA_BITS:1]};
                tx_left <= tx_left - 1'b1;
            end
        end else tx_cnt <= tx_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_io.sv
// UART-to-fabric bridge: host W/R frames become C2F requests; also a fabric target for TX bytes/status.
module uart_io
    import lotr_pkg::*;
    import uart_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2083,
    parameter int N_DATA_BITS  = 8,
    parameter int LSB_FIRST    = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  core_id,
    input  logic        uart_master_tx,
    output logic        uart_master_rx,
    input  logic        F2C_ReqValidQ502H,
    input  t_opcode     F2C_ReqOpcodeQ502H,
    input  logic [31:0] F2C_ReqAddressQ502H,
    input  logic [31:0] F2C_ReqDataQ502H,
    output logic        F2C_RspValidQ500H,
    output t_opcode     F2C_RspOpcodeQ500H,
    output logic [31:0] F2C_RspAddressQ500H,
    output logic [31:0] F2C_RspDataQ500H,
    output logic        C2F_ReqValidQ500H,
    output t_opcode     C2F_ReqOpcodeQ500H,
    output logic [1:0]  C2F_ReqThreadIDQ500H,
    output logic [31:0] C2F_ReqAddressQ500H,
    output logic [31:0] C2F_ReqDataQ500H,
    input  logic        C2F_RspValidQ502H,
    input  t_opcode     C2F_RspOpcodeQ502H,
    input  logic [1:0]  C2F_RspThreadIDQ502H,
    input  logic [31:0] C2F_RspDataQ502H,
    input  logic        C2F_RspStall
);
    logic [N_DATA_BITS-1:0] rx_data;
    logic                   rx_valid, rx_frame_err, tx_valid, tx_ready;
    logic [N_DATA_BITS-1:0] tx_data;
    logic [7:0]             rx_byte;

    uart_io_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT), .N_DATA_BITS(N_DATA_BITS), .LSB_FIRST(LSB_FIRST)
    ) u_phy (
        .clk(clk), .rstn(rstn), .rx_line(uart_master_tx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_line(uart_master_rx)
    );

    t_cmd_state  state;
    t_c2f_req    c2f_q;
    t_f2c_rsp    f2c_q;
    logic        is_wr, interrupt, buf_full, buf_fire, tx_busy, cmd_busy;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [7:0]  buf_data;
    logic        unused_req_data;

    assign rx_byte         = 8'(rx_data);
    assign unused_req_data = ^F2C_ReqDataQ502H[31:8];

    // Read-return bytes own the serializer for the whole 4-byte return
    assign tx_valid = (state == S_SEND) | buf_full;
    assign tx_data  = (state == S_SEND) ? N_DATA_BITS'(rdata_q[31:24]) : N_DATA_BITS'(buf_data);
    assign buf_fire = (state != S_SEND) & buf_full & tx_ready;
    assign tx_busy  = ~tx_ready | buf_full;
    assign cmd_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            c2f_q     <= '0;
            is_wr     <= 1'b0;
            interrupt <= 1'b0;
            byte_cnt  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_q   <= '0;
        end else begin
            interrupt <= 1'b0;
            unique case (state)
                S_IDLE: if (rx_valid && (rx_byte == CMD_WR || rx_byte == CMD_RD)) begin
                    is_wr    <= (rx_byte == CMD_WR);
                    byte_cnt <= '0;
                    state    <= S_ADDR;
                end
                S_ADDR: if (rx_frame_err) state <= S_IDLE;
                else if (rx_valid) begin
                    addr_q   <= {addr_q[23:0], rx_byte};
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) begin
                        if (is_wr) state <= S_DATA;
                        else begin
                            c2f_q.valid  <= 1'b1;
                            c2f_q.opcode <= RD;
                            c2f_q.tid    <= 2'd0;
                            c2f_q.addr   <= {addr_q[23:0], rx_byte};
                            c2f_q.data   <= 32'h0;
                            interrupt    <= 1'b1;
                            state        <= S_ISSUE_RD;
                        end
                    end
                end
                S_DATA: if (rx_frame_err) state <= S_IDLE;
                else if (rx_valid) begin
                    data_q   <= {data_q[23:0], rx_byte};
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) begin
                        c2f_q.valid  <= 1'b1;
                        c2f_q.opcode <= WR;
                        c2f_q.tid    <= 2'd0;
                        c2f_q.addr   <= addr_q;
                        c2f_q.data   <= {data_q[23:0], rx_byte};
                        interrupt    <= 1'b1;
                        state        <= S_ISSUE_WR;
                    end
                end
                S_ISSUE_WR, S_ISSUE_RD: if (!C2F_RspStall) begin
                    c2f_q.valid <= 1'b0;
                    state       <= (state == S_ISSUE_WR) ? S_IDLE : S_WAIT_RSP;
                end
                S_WAIT_RSP: if (C2F_RspValidQ502H && C2F_RspOpcodeQ502H == RD_RSP &&
                                C2F_RspThreadIDQ502H == 2'd0) begin
                    rdata_q  <= C2F_RspDataQ502H;
                    byte_cnt <= '0;
                    state    <= S_SEND;
                end
                S_SEND: if (tx_ready) begin
                    rdata_q  <= {rdata_q[23:0], 8'h0};
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Fabric target; a WR byte arriving while the buffer drains replaces it in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f2c_q    <= '0;
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            f2c_q.valid <= F2C_ReqValidQ502H;
            if (buf_fire) buf_full <= 1'b0;
            if (F2C_ReqValidQ502H) begin
                f2c_q.addr <= F2C_ReqAddressQ502H;
                if (F2C_ReqOpcodeQ502H == WR) begin
                    f2c_q.opcode <= WR_RSP;
                    f2c_q.data   <= 32'h0;
                    if (!buf_full || buf_fire) begin
                        buf_full <= 1'b1;
                        buf_data <= F2C_ReqDataQ502H[7:0];
                    end
                end else begin
                    f2c_q.opcode <= RD_RSP;
                    f2c_q.data   <= {16'h0, core_id, 6'h0, tx_busy, cmd_busy};
                end
            end
        end
    end

    assign C2F_ReqValidQ500H    = c2f_q.valid;
    assign C2F_ReqOpcodeQ500H   = c2f_q.opcode;
    assign C2F_ReqThreadIDQ500H = c2f_q.tid;
    assign C2F_ReqAddressQ500H  = c2f_q.addr;
    assign C2F_ReqDataQ500H     = c2f_q.data;
    assign F2C_RspValidQ500H    = f2c_q.valid;
    assign F2C_RspOpcodeQ500H   = f2c_q.opcode;
    assign F2C_RspAddressQ500H  = f2c_q.addr;
    assign F2C_RspDataQ500H     = f2c_q.data;
endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io: F2C vector table plus hand-written UART frame sequences.
module tb_uart_io;
    import lotr_pkg::*;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  core_id = 8'hAC;
    logic        uart_master_tx = 1'b1;
    logic        uart_master_rx;
    logic        F2C_ReqValidQ502H = 1'b0;
    t_opcode     F2C_ReqOpcodeQ502H = RD;
    logic [31:0] F2C_ReqAddressQ502H = '0, F2C_ReqDataQ502H = '0;
    logic        F2C_RspValidQ500H;
    t_opcode     F2C_RspOpcodeQ500H;
    logic [31:0] F2C_RspAddressQ500H, F2C_RspDataQ500H;
    logic        C2F_ReqValidQ500H;
    t_opcode     C2F_ReqOpcodeQ500H;
    logic [1:0]  C2F_ReqThreadIDQ500H;
    logic [31:0] C2F_ReqAddressQ500H, C2F_ReqDataQ500H;
    logic        C2F_RspValidQ502H = 1'b0;
    t_opcode     C2F_RspOpcodeQ502H = RD;
    logic [1:0]  C2F_RspThreadIDQ502H = '0;
    logic [31:0] C2F_RspDataQ502H = '0;
    logic        C2F_RspStall = 1'b0;

    always #5 clk = ~clk;

    uart_io #(.CLKS_PER_BIT(CPB), .N_DATA_BITS(8), .LSB_FIRST(0)) dut (
        .clk(clk), .rstn(rstn), .core_id(core_id),
        .uart_master_tx(uart_master_tx), .uart_master_rx(uart_master_rx),
        .F2C_ReqValidQ502H(F2C_ReqValidQ502H), .F2C_ReqOpcodeQ502H(F2C_ReqOpcodeQ502H),
        .F2C_ReqAddressQ502H(F2C_ReqAddressQ502H), .F2C_ReqDataQ502H(F2C_ReqDataQ502H),
        .F2C_RspValidQ500H(F2C_RspValidQ500H), .F2C_RspOpcodeQ500H(F2C_RspOpcodeQ500H),
        .F2C_RspAddressQ500H(F2C_RspAddressQ500H), .F2C_RspDataQ500H(F2C_RspDataQ500H),
        .C2F_ReqValidQ500H(C2F_ReqValidQ500H), .C2F_ReqOpcodeQ500H(C2F_ReqOpcodeQ500H),
        .C2F_ReqThreadIDQ500H(C2F_ReqThreadIDQ500H), .C2F_ReqAddressQ500H(C2F_ReqAddressQ500H),
        .C2F_ReqDataQ500H(C2F_ReqDataQ500H),
        .C2F_RspValidQ502H(C2F_RspValidQ502H), .C2F_RspOpcodeQ502H(C2F_RspOpcodeQ502H),
        .C2F_RspThreadIDQ502H(C2F_RspThreadIDQ502H), .C2F_RspDataQ502H(C2F_RspDataQ502H),
        .C2F_RspStall(C2F_RspStall)
    );

    typedef struct {
        t_opcode     op;
        logic [1:0]  tid;
        logic [31:0] addr;
        logic [31:0] data;
    } c2f_rec_t;

    typedef struct {
        logic        vld;
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  cid;
        logic        exp_vld;
        t_opcode     exp_op;
        logic        chk_data;
        logic [31:0] exp_data;
    } f2c_vec_t;

    c2f_rec_t   c2f_log[$];
    logic [7:0] rx_chars[$];
    int         valid_cycles = 0;
    int         unstable = 0;
    int         intr_pulses = 0;
    int         checks = 0;
    int         errors = 0;

    // Monitors sample on the falling edge, mid-cycle
    initial begin
        logic        prev_vld;
        logic [67:0] prev_fields;
        prev_vld    = 1'b0;
        prev_fields = '0;
        forever begin
            @(negedge clk);
            if (dut.interrupt) intr_pulses++;
            if (C2F_ReqValidQ500H) begin
                valid_cycles++;
                if (prev_vld && prev_fields != {C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
                                                C2F_ReqAddressQ500H, C2F_ReqDataQ500H})
                    unstable++;
                if (!C2F_RspStall)
                    c2f_log.push_back('{C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
                                        C2F_ReqAddressQ500H, C2F_ReqDataQ500H});
            end
            prev_vld    = C2F_ReqValidQ500H;
            prev_fields = {C2F_ReqOpcodeQ500H, C2F_ReqThreadIDQ500H,
                           C2F_ReqAddressQ500H, C2F_ReqDataQ500H};
        end
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_master_rx);
            repeat (CPB / 2) @(negedge clk);
            if (!uart_master_rx) begin
                b = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b = {b[6:0], uart_master_rx};
                end
                repeat (CPB) @(negedge clk);
                rx_chars.push_back(b);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] b, input logic stop_bit, input bit tail);
        uart_master_tx = 1'b0;
        tick(CPB);
        for (int i = 7; i >= 0; i--) begin
            uart_master_tx = b[i];
            tick(CPB);
        end
        uart_master_tx = stop_bit;
        if (tail) begin
            tick(CPB);
            uart_master_tx = 1'b1;
            tick(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                              input int nbytes, input bit tail);
        logic [63:0] payload;
        payload = {a, d};
        send_char(cmd, 1'b1, 1'b1);
        for (int i = 0; i < nbytes; i++)
            send_char(payload[63-8*i -: 8], 1'b1, tail || i != nbytes - 1);
    endtask

    task automatic f2c_req(input t_opcode op, input logic [31:0] a, input logic [31:0] d);
        F2C_ReqValidQ502H   = 1'b1;
        F2C_ReqOpcodeQ502H  = op;
        F2C_ReqAddressQ502H = a;
        F2C_ReqDataQ502H    = d;
        tick(1);
        F2C_ReqValidQ502H   = 1'b0;
    endtask

    task automatic wait_req(input int base, input string nm);
        int n = 0;
        while (c2f_log.size() <= base && n < 400) begin
            tick(1);
            n++;
        end
        chk(nm, 32'(c2f_log.size() > base), 32'd1);
    endtask

    task automatic wait_chars(input int base, input int cnt, input string nm);
        int n = 0;
        while (rx_chars.size() < base + cnt && n < 2500) begin
            tick(1);
            n++;
        end
        chk(nm, 32'(rx_chars.size() >= base + cnt), 32'd1);
    endtask

    task automatic chk_req(input string nm, input int idx, input t_opcode op,
                           input logic [31:0] a, input logic [31:0] d);
        if (idx >= c2f_log.size()) begin
            chk({nm, "_present"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_op"}, 32'(c2f_log[idx].op), 32'(op));
            chk({nm, "_tid"}, 32'(c2f_log[idx].tid), 32'd0);
            chk({nm, "_addr"}, c2f_log[idx].addr, a);
            chk({nm, "_data"}, c2f_log[idx].data, d);
        end
    endtask

    initial begin
        f2c_vec_t vecs[8];
        int req_base, chr_base, intr_base, vc_base, us_base;

        vecs[0] = '{1'b1, RD, 32'h100, 32'h0,  8'hAC, 1'b1, RD_RSP, 1'b1, 32'h0000AC00};
        vecs[1] = '{1'b0, RD, 32'h0,   32'h0,  8'hAC, 1'b0, RD,     1'b0, 32'h0};
        vecs[2] = '{1'b1, RD, 32'h104, 32'h0,  8'h3C, 1'b1, RD_RSP, 1'b1, 32'h00003C00};
        vecs[3] = '{1'b1, WR, 32'h200, 32'h55, 8'hAC, 1'b1, WR_RSP, 1'b0, 32'h0};
        vecs[4] = '{1'b1, RD, 32'h108, 32'h0,  8'hAC, 1'b1, RD_RSP, 1'b1, 32'h0000AC02};
        vecs[5] = '{1'b1, WR, 32'h204, 32'h77, 8'hAC, 1'b1, WR_RSP, 1'b0, 32'h0};
        vecs[6] = '{1'b1, WR, 32'h208, 32'h99, 8'hAC, 1'b1, WR_RSP, 1'b0, 32'h0};
        vecs[7] = '{1'b1, RD, 32'h10C, 32'h0,  8'hAC, 1'b1, RD_RSP, 1'b1, 32'h0000AC02};

        tick(3);
        chk("rst_line", 32'(uart_master_rx), 32'd1);
        chk("rst_c2f_valid", 32'(C2F_ReqValidQ500H), 32'd0);
        chk("rst_c2f_addr", C2F_ReqAddressQ500H, 32'd0);
        chk("rst_f2c_valid", 32'(F2C_RspValidQ500H), 32'd0);
        chk("rst_f2c_data", F2C_RspDataQ500H, 32'd0);
        chk("rst_intr", 32'(dut.interrupt), 32'd0);
        rstn = 1'b1;
        tick(4);

        // F2C target vectors, one request per cycle back to back
        chr_base = rx_chars.size();
        for (int i = 0; i < 8; i++) begin
            core_id = vecs[i].cid;
            if (vecs[i].vld) f2c_req(vecs[i].op, vecs[i].addr, vecs[i].data);
            else tick(1);
            chk($sformatf("f2c%0d_valid", i), 32'(F2C_RspValidQ500H), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("f2c%0d_op", i), 32'(F2C_RspOpcodeQ500H), 32'(vecs[i].exp_op));
                chk($sformatf("f2c%0d_addr", i), F2C_RspAddressQ500H, vecs[i].addr);
                if (vecs[i].chk_data)
                    chk($sformatf("f2c%0d_data", i), F2C_RspDataQ500H, vecs[i].exp_data);
            end
        end
        tick(1);
        chk("f2c_single_cycle", 32'(F2C_RspValidQ500H), 32'd0);
        core_id = 8'hAC;
        wait_chars(chr_base, 2, "f2c_tx_arrive");
        tick(250);
        chk("f2c_tx_count", 32'(rx_chars.size() - chr_base), 32'd2);
        if (rx_chars.size() >= chr_base + 2) begin
            chk("f2c_tx_char0", 32'(rx_chars[chr_base]), 32'h55);
            chk("f2c_tx_char1", 32'(rx_chars[chr_base + 1]), 32'h77);
        end

        // Plain write frame
        req_base  = c2f_log.size();
        intr_base = intr_pulses;
        send_frame(8'h57, 32'h12345678, 32'hDEADBEEF, 8, 1'b1);
        wait_req(req_base, "wr_issued");
        tick(5);
        chk("wr_count", 32'(c2f_log.size() - req_base), 32'd1);
        chk("wr_intr", 32'(intr_pulses - intr_base), 32'd1);
        chk_req("wr", req_base, WR, 32'h12345678, 32'hDEADBEEF);

        // Read frame; wrong-thread and WR_RSP responses must be ignored
        req_base = c2f_log.size();
        chr_base = rx_chars.size();
        send_frame(8'h52, 32'h00400010, 32'h0, 4, 1'b1);
        wait_req(req_base, "rd_issued");
        chk_req("rd", req_base, RD, 32'h00400010, 32'h0);
        C2F_RspValidQ502H = 1'b1;
        C2F_RspOpcodeQ502H = RD_RSP; C2F_RspThreadIDQ502H = 2'd1; C2F_RspDataQ502H = 32'h11111111;
        tick(1);
        C2F_RspOpcodeQ502H = WR_RSP; C2F_RspThreadIDQ502H = 2'd0; C2F_RspDataQ502H = 32'h22222222;
        tick(1);
        C2F_RspValidQ502H = 1'b0;
        tick(3);
        C2F_RspValidQ502H = 1'b1;
        C2F_RspOpcodeQ502H = RD_RSP; C2F_RspThreadIDQ502H = 2'd0; C2F_RspDataQ502H = 32'hCAFEF00D;
        tick(1);
        C2F_RspValidQ502H = 1'b0;
        wait_chars(chr_base, 4, "rd_return_arrive");
        if (rx_chars.size() >= chr_base + 4) begin
            chk("rd_ret0", 32'(rx_chars[chr_base]), 32'hCA);
            chk("rd_ret1", 32'(rx_chars[chr_base + 1]), 32'hFE);
            chk("rd_ret2", 32'(rx_chars[chr_base + 2]), 32'hF0);
            chk("rd_ret3", 32'(rx_chars[chr_base + 3]), 32'h0D);
        end
        tick(2 * CPB);

        // Stall held for the first three issue cycles
        req_base = c2f_log.size();
        vc_base  = valid_cycles;
        us_base  = unstable;
        C2F_RspStall = 1'b1;
        send_frame(8'h57, 32'hA0B0C0D0, 32'h01020304, 8, 1'b0);
        begin
            int n = 0;
            while (!C2F_ReqValidQ500H && n < 100) begin
                tick(1);
                n++;
            end
        end
        chk("stall_valid_seen", 32'(C2F_ReqValidQ500H), 32'd1);
        tick(3);
        C2F_RspStall = 1'b0;
        tick(5);
        chk("stall_valid_cycles", 32'(valid_cycles - vc_base), 32'd4);
        chk("stall_stable", 32'(unstable - us_base), 32'd0);
        chk("stall_accept_once", 32'(c2f_log.size() - req_base), 32'd1);
        chk_req("stall", req_base, WR, 32'hA0B0C0D0, 32'h01020304);
        tick(2 * CPB);

        // Junk byte before a write frame
        req_base  = c2f_log.size();
        intr_base = intr_pulses;
        send_char(8'h41, 1'b1, 1'b1);
        send_frame(8'h57, 32'h87654321, 32'h0BADF00D, 8, 1'b1);
        wait_req(req_base, "junk_wr_issued");
        tick(5);
        chk("junk_count", 32'(c2f_log.size() - req_base), 32'd1);
        chk("junk_intr", 32'(intr_pulses - intr_base), 32'd1);
        chk_req("junk", req_base, WR, 32'h87654321, 32'h0BADF00D);

        // Framing error mid-address drops the frame
        req_base  = c2f_log.size();
        intr_base = intr_pulses;
        send_char(8'h57, 1'b1, 1'b1);
        send_char(8'h11, 1'b1, 1'b1);
        send_char(8'h22, 1'b1, 1'b1);
        send_char(8'h33, 1'b1, 1'b1);
        send_char(8'h44, 1'b0, 1'b1);
        send_char(8'h55, 1'b1, 1'b1);
        send_char(8'h66, 1'b1, 1'b1);
        send_char(8'h77, 1'b1, 1'b1);
        send_char(8'h88, 1'b1, 1'b1);
        send_char(8'h99, 1'b1, 1'b1);
        tick(20);
        chk("ferr_no_req", 32'(c2f_log.size() - req_base), 32'd0);
        chk("ferr_no_intr", 32'(intr_pulses - intr_base), 32'd0);
        f2c_req(RD, 32'h300, 32'h0);
        chk("ferr_idle_status", F2C_RspDataQ500H, 32'h0000AC00);

        // Reset in the middle of a write frame and of an F2C TX byte
        req_base  = c2f_log.size();
        intr_base = intr_pulses;
        send_frame(8'h57, 32'h12345678, 32'h0, 4, 1'b1);
        f2c_req(RD, 32'h304, 32'h0);
        chk("partial_busy_status", F2C_RspDataQ500H, 32'h0000AC01);
        f2c_req(WR, 32'h308, 32'h5A);
        tick(40);
        rstn = 1'b0;
        tick(1);
        chk("midrst_line", 32'(uart_master_rx), 32'd1);
        chk("midrst_c2f_valid", 32'(C2F_ReqValidQ500H), 32'd0);
        chk("midrst_c2f_data", C2F_ReqDataQ500H, 32'd0);
        chk("midrst_f2c_valid", 32'(F2C_RspValidQ500H), 32'd0);
        chk("midrst_f2c_addr", F2C_RspAddressQ500H, 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(200);
        chr_base = rx_chars.size();
        send_char(8'hDE, 1'b1, 1'b1);
        send_char(8'hAD, 1'b1, 1'b1);
        send_char(8'hBE, 1'b1, 1'b1);
        send_char(8'hEF, 1'b1, 1'b1);
        tick(40);
        chk("rst_no_req", 32'(c2f_log.size() - req_base), 32'd0);
        chk("rst_no_intr", 32'(intr_pulses - intr_base), 32'd0);
        chk("rst_no_tx", 32'(rx_chars.size() - chr_base), 32'd0);
        f2c_req(RD, 32'h30C, 32'h0);
        chk("rst_idle_status", F2C_RspDataQ500H, 32'h0000AC00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
